// File: rtl/m_unit_if.sv
// Issue/return bundle between the execute stage and the RV32M multiply/divide unit.
interface m_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       func3;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [4:0]       rd_in;
    logic             wr_in;
    logic             flush;
    logic [WIDTH-1:0] result;
    logic             ready;
    logic [4:0]       dest;
    logic             wr;
    logic             busy;

    modport master (
        output start, func3, op1, op2, rd_in, wr_in, flush,
        input  result, ready, dest, wr, busy
    );

    modport slave (
        input  start, func3, op1, op2, rd_in, wr_in, flush,
        output result, ready, dest, wr, busy
    );
endinterface

// File: rtl/m_unit.sv
// Iterative RV32M unit: fixed-latency multiply, 32-step restoring divide with a sign-fix pass.
module m_unit #(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 2
) (
    input logic   clk,
    input logic   rst,
    m_unit_if.slave bus
);
    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic             setup_q, setup_d;
    logic [1:0]       f3_q, f3_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [4:0]       rd_q, rd_d;
    logic             wrl_q, wrl_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [4:0]       dest_q, dest_d;

    logic signed [WIDTH:0]     mul_a, mul_b;
    logic signed [2*WIDTH-1:0] prod;
    logic [WIDTH:0]            rem_sh;
    logic                      sgn, a_neg, b_neg, div0, ovf;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    // MULH and MULHSU treat op1 as signed; only MULH treats op2 as signed.
    assign mul_a  = signed'({(f3_q[1] ^ f3_q[0]) & a_q[WIDTH-1], a_q});
    assign mul_b  = signed'({(f3_q == 2'b01) & b_q[WIDTH-1], b_q});
    assign prod   = (2*WIDTH)'(mul_a) * (2*WIDTH)'(mul_b);

    assign sgn    = ~f3_q[0];
    assign a_neg  = sgn & a_q[WIDTH-1];
    assign b_neg  = sgn & b_q[WIDTH-1];
    assign div0   = (b_q == '0);
    assign ovf    = sgn && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
    assign rem_sh = {rem_q, quo_q[WIDTH-1]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        setup_d  = setup_q;
        f3_d     = f3_q;
        a_d      = a_q;
        b_d      = b_q;
        rd_d     = rd_q;
        wrl_d    = wrl_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        dest_d   = dest_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    a_d     = bus.op1;
                    b_d     = bus.op2;
                    f3_d    = bus.func3[1:0];
                    rd_d    = bus.rd_in;
                    wrl_d   = bus.wr_in;
                    cnt_d   = '0;
                    setup_d = 1'b1;
                    state_d = bus.func3[2] ? DIV : MUL;
                end
                MUL: begin
                    if (cnt_q == 6'(MUL_LATENCY - 1)) begin
                        result_d = (f3_q == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
                        dest_d   = rd_q;
                        state_d  = DONE;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                DIV: begin
                    if (setup_q) begin
                        setup_d = 1'b0;
                        cnt_d   = '0;
                        // Special cases preload the final answer and skip the iterations.
                        if (div0) begin
                            quo_d   = '1;
                            rem_d   = a_q;
                            qneg_d  = 1'b0;
                            rneg_d  = 1'b0;
                            state_d = FIX;
                        end else if (ovf) begin
                            quo_d   = a_q;
                            rem_d   = '0;
                            qneg_d  = 1'b0;
                            rneg_d  = 1'b0;
                            state_d = FIX;
                        end else begin
                            quo_d  = cond_neg(a_q, a_neg);
                            dvs_d  = cond_neg(b_q, b_neg);
                            rem_d  = '0;
                            qneg_d = a_neg ^ b_neg;
                            rneg_d = a_neg;
                        end
                    end else begin
                        if (rem_sh >= {1'b0, dvs_q}) begin
                            rem_d = rem_sh[WIDTH-1:0] - dvs_q;
                            quo_d = {quo_q[WIDTH-2:0], 1'b1};
                        end else begin
                            rem_d = rem_sh[WIDTH-1:0];
                            quo_d = {quo_q[WIDTH-2:0], 1'b0};
                        end
                        if (cnt_q == 6'd31) state_d = FIX;
                        else                cnt_d   = cnt_q + 6'd1;
                    end
                end
                FIX: begin
                    result_d = f3_q[1] ? cond_neg(rem_q, rneg_q) : cond_neg(quo_q, qneg_q);
                    dest_d   = rd_q;
                    state_d  = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            setup_q  <= 1'b0;
            f3_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rd_q     <= '0;
            wrl_q    <= 1'b0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            dest_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            setup_q  <= setup_d;
            f3_q     <= f3_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rd_q     <= rd_d;
            wrl_q    <= wrl_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            dest_q   <= dest_d;
        end
    end

    assign bus.result = result_q;
    assign bus.dest   = dest_q;
    assign bus.ready  = (state_q == DONE);
    assign bus.wr     = (state_q == DONE) & wrl_q;
    assign bus.busy   = (state_q != IDLE);
endmodule

// File: tb/tb_m_unit.sv
// Directed bench for m_unit: vector table for result/latency plus corner-case sequences.
module tb_m_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;

    m_unit_if #(.WIDTH(32)) bus ();
    m_unit #(.WIDTH(32), .MUL_LATENCY(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wr;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic wr);
        @(negedge clk);
        bus.func3 = f3; bus.op1 = a; bus.op2 = b; bus.rd_in = rd; bus.wr_in = wr;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_ready(input int lim, output int lat, output bit busy_ok);
        lat = -1;
        busy_ok = 1'b1;
        for (int k = 1; k <= lim; k++) begin
            @(posedge clk);
            #1;
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (bus.ready === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic no_ready(input int n, output bit ok);
        ok = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (bus.ready !== 1'b0) ok = 1'b0;
        end
    endtask

    initial begin
        int lat;
        bit ok;

        vecs[0]  = '{"mul",        3'b000, 32'hFFFFFFFF, 32'h2,        5'd5,  1'b1, 32'hFFFFFFFE, 2};
        vecs[1]  = '{"mulh",       3'b001, 32'hFFFFFFFF, 32'h2,        5'd5,  1'b1, 32'hFFFFFFFF, 2};
        vecs[2]  = '{"mulhu",      3'b011, 32'hFFFFFFFF, 32'h2,        5'd5,  1'b1, 32'h00000001, 2};
        vecs[3]  = '{"mulhsu",     3'b010, 32'hFFFFFFFF, 32'h2,        5'd5,  1'b1, 32'hFFFFFFFF, 2};
        vecs[4]  = '{"mul_x0",     3'b000, 32'h7,        32'h6,        5'd0,  1'b0, 32'h0000002A, 2};
        vecs[5]  = '{"div_m7_2",   3'b100, 32'hFFFFFFF9, 32'h2,        5'd6,  1'b1, 32'hFFFFFFFD, 34};
        vecs[6]  = '{"rem_m7_2",   3'b110, 32'hFFFFFFF9, 32'h2,        5'd7,  1'b1, 32'hFFFFFFFF, 34};
        vecs[7]  = '{"divu",       3'b101, 32'hFFFFFFF9, 32'h2,        5'd8,  1'b1, 32'h7FFFFFFC, 34};
        vecs[8]  = '{"remu",       3'b111, 32'hFFFFFFF9, 32'h2,        5'd8,  1'b1, 32'h00000001, 34};
        vecs[9]  = '{"div_100_m7", 3'b100, 32'd100,      32'hFFFFFFF9, 5'd10, 1'b1, 32'hFFFFFFF2, 34};
        vecs[10] = '{"rem_100_m7", 3'b110, 32'd100,      32'hFFFFFFF9, 5'd11, 1'b1, 32'h00000002, 34};
        vecs[11] = '{"divu_by0",   3'b101, 32'h1234,     32'h0,        5'd12, 1'b1, 32'hFFFFFFFF, 2};
        vecs[12] = '{"remu_by0",   3'b111, 32'h1234,     32'h0,        5'd13, 1'b1, 32'h00001234, 2};
        vecs[13] = '{"div_ovf",    3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd14, 1'b1, 32'h80000000, 2};
        vecs[14] = '{"rem_ovf",    3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd15, 1'b1, 32'h00000000, 2};

        bus.start = 1'b0; bus.flush = 1'b0; bus.func3 = '0;
        bus.op1 = '0; bus.op2 = '0; bus.rd_in = '0; bus.wr_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {bus.result, 3'b0, bus.dest, 22'b0, bus.ready, bus.wr, bus.busy}, '0);
        @(negedge clk) rst = 1'b0;

        foreach (vecs[i]) begin
            issue(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].wr);
            wait_ready(60, lat, ok);
            check({vecs[i].name, "_latency"}, lat, vecs[i].lat);
            check({vecs[i].name, "_result"}, bus.result, vecs[i].exp);
            check({vecs[i].name, "_dest"}, 32'(bus.dest), 32'(vecs[i].rd));
            check({vecs[i].name, "_wr"}, 32'(bus.wr), 32'(vecs[i].wr));
            check({vecs[i].name, "_busy_held"}, 32'(ok), 32'd1);
            @(posedge clk);
            #1;
            check({vecs[i].name, "_pulse_end"}, {30'b0, bus.ready, bus.busy}, 32'd0);
        end

        // start while busy at E0+5 must not disturb the divide in flight
        issue(3'b100, 32'd100, 32'hFFFFFFF9, 5'd4, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.func3 = 3'b000; bus.op1 = 32'd3; bus.op2 = 32'd3; bus.rd_in = 5'd7; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_ready(60, lat, ok);
        check("busy_start_latency", lat, 29);
        check("busy_start_result", bus.result, 32'hFFFFFFF2);
        check("busy_start_dest", 32'(bus.dest), 32'd4);
        @(posedge clk);
        #1;
        check("busy_start_idle", 32'(bus.busy), 32'd0);

        // flush at E0+10 aborts the divide
        issue(3'b100, 32'hFFFFFFF9, 32'h2, 5'd6, 1'b1);
        repeat (9) @(posedge clk);
        @(negedge clk) bus.flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush_busy", {30'b0, bus.ready, bus.busy}, 32'd0);
        bus.flush = 1'b0;
        no_ready(40, ok);
        check("flush_no_ready", 32'(ok), 32'd1);

        // start and flush together in IDLE: nothing accepted
        @(negedge clk);
        bus.func3 = 3'b000; bus.op1 = 32'd2; bus.op2 = 32'd2; bus.start = 1'b1; bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        check("start_flush_busy", 32'(bus.busy), 32'd0);
        no_ready(10, ok);
        check("start_flush_no_ready", 32'(ok), 32'd1);

        // back-to-back: start held through the DONE cycle is accepted only the cycle after
        issue(3'b000, 32'd3, 32'd5, 5'd3, 1'b1);
        wait_ready(10, lat, ok);
        check("b2b_first_result", bus.result, 32'h0000000F);
        @(negedge clk);
        bus.func3 = 3'b000; bus.op1 = 32'h0000FFFF; bus.op2 = 32'h00010001;
        bus.rd_in = 5'd9; bus.wr_in = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        #1;
        check("b2b_idle_after_ready", {30'b0, bus.ready, bus.busy}, 32'd0);
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_ready(10, lat, ok);
        check("b2b_second_latency", lat, 2);
        check("b2b_second_result", bus.result, 32'hFFFFFFFF);
        check("b2b_second_dest", 32'(bus.dest), 32'd9);
        check("b2b_second_wr", 32'(bus.wr), 32'd0);

        // reset mid-divide clears everything and drops the operation
        issue(3'b101, 32'hFFFFFFF9, 32'h2, 5'd21, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mid_outputs", {bus.result, 3'b0, bus.dest, 22'b0, bus.ready, bus.wr, bus.busy}, '0);
        @(negedge clk) rst = 1'b0;
        no_ready(40, ok);
        check("rst_mid_no_ready", 32'(ok), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
